// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Controller states; the encoding values are fixed so the state register
    // can be decoded directly by debug tooling.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell: diff = a - b - borrow_in, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow
);

    // Difference bit and borrow generation for a single bit position.
    always_comb begin
        diff   = a ^ b ^ borrow_in;
        borrow = (~a & b) | (~(a ^ b) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial, LSB-first subtractor: diff = a - b - borrow_in over WIDTH
// cycles using one full_subtractor cell and a registered borrow.
// Handshake: start (sampled in IDLE) / busy / one-cycle done pulse.
// Optional feature: define SERIAL_SUBTRACTOR_OVERFLOW_EN to add the
// 'overflow' output (signed two's-complement overflow of the operation).
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             brw_r;
    logic [CNT_W-1:0] cnt_r;
    logic             d_s;
    logic             bo_s;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             ovf_r;
`endif

    // The single bit cell always looks at the current LSBs and borrow flop.
    full_subtractor u_cell (
        .a         (a_sr_r[0]),
        .b         (b_sr_r[0]),
        .borrow_in (brw_r),
        .diff      (d_s),
        .borrow    (bo_s)
    );

    // Controller and serial datapath: state, shift registers, counter and
    // all registered outputs update together on the rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            a_sr_r     <= '0;
            b_sr_r     <= '0;
            res_sr_r   <= '0;
            brw_r      <= 1'b0;
            cnt_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf_r      <= 1'b0;
            overflow   <= 1'b0;
`endif
        end else begin
            // done is a pulse; only the DONE branch raises it.
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        brw_r   <= borrow_in;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    res_sr_r <= {d_s, res_sr_r[WIDTH-1:1]};
                    brw_r    <= bo_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_BIT) begin
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                        // Borrow into the MSB xor borrow out of the MSB.
                        ovf_r <= brw_r ^ bo_s;
`endif
                        state_r <= DONE;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    diff       <= res_sr_r;
                    borrow_out <= brw_r;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    overflow   <= ovf_r;
`endif
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: the driver pushes expected results
// computed with plain integer arithmetic; a monitor pops them on each done.
`timescale 1ns/1ps
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             borrow_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             overflow;
`endif

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        ,
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bo;
        logic             ovf;
        int               due;
    } exp_t;

    exp_t             q[$];
    int               cyc = 0;
    int               n_checks = 0;
    int               n_fail = 0;
    bit               abort_flag = 1'b0;
    logic [WIDTH-1:0] last_diff = '0;

    // Edge counter used to timestamp acceptance and completion.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: unsigned and signed integer subtraction.
    task automatic push_exp(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic bi, input int acc);
        exp_t        e;
        int          full;
        int          s;
        logic [31:0] tmp;
        full  = int'(av) - int'(bv) - int'(bi);
        tmp   = full;
        s     = int'($signed(av)) - int'($signed(bv)) - int'(bi);
        e.diff = tmp[WIDTH-1:0];
        e.bo   = (full < 0);
        e.ovf  = (s > (2**(WIDTH-1)) - 1) || (s < -(2**(WIDTH-1)));
        e.due  = acc + WIDTH + 1;
        q.push_back(e);
    endtask

    // Issue one request while the DUT is idle; scramble operands afterwards.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; borrow_in = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        push_exp(av, bv, bi, cyc);
        a = WIDTH'($urandom); b = WIDTH'($urandom); borrow_in = 1'($urandom);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    // Monitor: compare every done against the scoreboard, and check busy runs.
    initial begin : monitor
        exp_t e;
        int   busy_run;
        busy_run = 0;
        forever begin
            @(negedge clk);
            if (done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    last_diff = e.diff;
                    chk("diff", diff, e.diff);
                    chk("borrow_out", borrow_out, e.bo);
                    chk("done_latency", cyc, e.due);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    chk("overflow", overflow, e.ovf);
`endif
                end
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                if (!abort_flag) chk("busy_cycles", busy_run, WIDTH + 1);
                abort_flag = 1'b0;
                busy_run = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        // Reset state.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow_out", borrow_out, 0);
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
        chk("rst_overflow", overflow, 0);
`endif
        reset = 1'b0;

        // Basic operation and result hold.
        do_op(8'h35, 8'h12, 1'b0);
        wait_idle();
        repeat (3) @(negedge clk);
        chk("diff_hold", diff, last_diff);

        // Underflow, then borrow_in consumed exactly.
        do_op(8'h00, 8'h01, 1'b0);
        wait_idle();
        do_op(8'h10, 8'h0F, 1'b1);
        wait_idle();

        // Start re-pulsed mid-SHIFT must be dropped.
        do_op(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        a = 8'h01; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Reset four cycles into SHIFT aborts with no done pulse.
        do_op(8'h77, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        abort_flag = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_borrow_out", borrow_out, 0);
        repeat (12) @(negedge clk);
        do_op(8'h40, 8'h41, 1'b0);
        wait_idle();

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(negedge clk);
        a = 8'h03; b = 8'h01; borrow_in = 1'b0; start = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            @(negedge clk);
            push_exp(8'h03, 8'h01, 1'b0, cyc);
            if (n == 3) begin
                start = 1'b0;
            end else begin
                repeat (WIDTH + 1) @(posedge clk);
            end
        end
        wait_idle();

        // Signed overflow corner cases (overflow only checked when enabled).
        do_op(8'h80, 8'h01, 1'b0);
        wait_idle();
        do_op(8'h05, 8'h03, 1'b0);
        wait_idle();
        do_op(8'h7F, 8'hFF, 1'b0);
        wait_idle();

        // Randomized operations with random idle gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_idle();
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor: computes diff = a - b - borrow_in over WIDTH clock cycles using a single one-bit full-subtractor cell and a registered borrow.
- Inverse arithmetic counterpart of the team's full-adder cell, in the Combinational_Logic/arithmetic family.
- Serves as an area-cheap subtract unit for multi-cycle datapaths, with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range >= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden).

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend, captured on accepted start.
- b  input  WIDTH  subtrahend, captured on accepted start.
- borrow_in  input  1  initial borrow, captured on accepted start.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result; held stable from done until the next accepted start.
- borrow_out  output  1  final borrow (1 when a < b + borrow_in, unsigned).

Behaviour:
- Reset (synchronous, reset=1 at an edge): state=IDLE; busy=0, done=0, diff=0, borrow_out=0; shift registers, borrow flop and counter cleared. Reset wins over every other input in the same cycle.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1: load a_sr<=a, b_sr<=b, brw<=borrow_in, cnt<=0, state<=SHIFT. diff and borrow_out are not cleared here; they change only as described below.
- IDLE, start=0: hold all state.
- SHIFT, each cycle:
  - Bit cell inputs: x=a_sr[0], y=b_sr[0], bi=brw.
  - d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
  - a_sr and b_sr shift right by one.
  - Result register shifts right with d inserted at the MSB.
  - brw<=bo; cnt<=cnt+1.
  - When cnt==WIDTH-1, next state is DONE.
- DONE: diff=result register, borrow_out=brw, done=1 for exactly this cycle; next state IDLE.
- Latency: start accepted at edge k; done high during the cycle after edge k+WIDTH+1, i.e. WIDTH+1 cycles after acceptance. Throughput is one operation per WIDTH+2 cycles.
- start while busy (SHIFT or DONE): ignored, with no effect on the operation in flight. A start held high through DONE is accepted in the following IDLE cycle.
- Operand changes after acceptance: no effect; operands are captured at acceptance.
- Reset mid-operation: aborts immediately and returns everything to reset values; no done pulse is produced.
- Arithmetic is modulo 2^WIDTH. borrow_out equals the unsigned underflow of the full WIDTH-bit subtraction.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- Defined:
  - Extra output port overflow (1 bit) = signed two's-complement overflow of a - b - borrow_in, computed as the borrow into the MSB XOR the borrow out of the MSB.
  - Captured in the last SHIFT cycle; valid and held with diff.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_subtractor_pkg holds:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default WIDTH constant.
- One sub-module: full_subtractor (combinational cell: inputs a, b, borrow_in; outputs diff, borrow), instantiated once in the SHIFT datapath.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, borrow_in=0, pulse start -> done exactly 9 cycles after acceptance, diff=0x23, borrow_out=0, busy high for 9 cycles.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Then a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0.
- Start accepted with a=0xAA, b=0x55; start re-pulsed mid-SHIFT with a=0x01, b=0x01 -> exactly one done, diff=0x55; second request dropped.
- reset asserted 4 cycles into SHIFT -> next cycle busy=0, done=0, diff=0, borrow_out=0, no done pulse; a fresh start afterwards computes correctly.
- start held high continuously, a=0x03, b=0x01 -> back-to-back operations with done every 10 cycles, diff=0x02 each time.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN defined:
  - a=0x80, b=0x01 -> diff=0x7F, overflow=1, borrow_out=0.
  - a=0x05, b=0x03 -> overflow=0.
